// File: rtl/uart_rx.sv
// 8N1 serial receiver: 8x oversampling, sticky line errors,
// and a byte FIFO drained through a request/ready read port.
module uart_rx #(
  parameter int PRESCALE = 50000000 / (9600 * 8),
  parameter int DEPTH    = 64
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_empty,
  output logic        o_overrun,
  output logic        o_framing_error,
  input  logic        i_clear_errors,
  input  logic        UART_RX
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRK
  } state_t;

  state_t      state, state_d;
  logic        sync1, rx_s, rx_prev;
  logic [CW-1:0] cnt;
  logic        tick;
  logic [2:0]  scount, scount_d;
  logic [2:0]  bidx, bidx_d;
  logic [7:0]  shreg, shreg_d;
  logic        reload, push, pop;
  logic        ovr_set, fe_set;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        full, empty;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= UART_RX;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  assign tick = (cnt == '0);

  // Reloading on the start edge phase-aligns every later sample.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)       cnt <= RELOAD;
    else if (reload)    cnt <= RELOAD;
    else if (tick)      cnt <= RELOAD;
    else                cnt <= cnt - 1'b1;
  end

  always_comb begin
    state_d  = state;
    scount_d = scount;
    bidx_d   = bidx;
    shreg_d  = shreg;
    reload   = 1'b0;
    push     = 1'b0;
    ovr_set  = 1'b0;
    fe_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          reload   = 1'b1;
          scount_d = 3'd0;
          state_d  = START;
        end
      end
      START: begin
        if (tick) begin
          scount_d = scount + 3'd1;
          if (scount == 3'd3) begin
            scount_d = 3'd0;
            bidx_d   = 3'd0;
            state_d  = rx_s ? IDLE : DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          scount_d = scount + 3'd1;
          if (scount == 3'd7) begin
            shreg_d = {rx_s, shreg[7:1]};
            bidx_d  = bidx + 3'd1;
            if (bidx == 3'd7) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          scount_d = scount + 3'd1;
          if (scount == 3'd7) begin
            if (rx_s) begin
              push    = !full;
              ovr_set = full;
              state_d = IDLE;
            end else begin
              fe_set  = 1'b1;
              state_d = BRK;
            end
          end
        end
      end
      BRK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state  <= IDLE;
      scount <= 3'd0;
      bidx   <= 3'd0;
      shreg  <= 8'd0;
    end else begin
      state  <= state_d;
      scount <= scount_d;
      bidx   <= bidx_d;
      shreg  <= shreg_d;
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = i_request && !o_ready && !empty;
  assign o_empty = empty;

  always_ff @(posedge i_clock) begin
    if (push) mem[wptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wptr            <= '0;
      rptr            <= '0;
      o_ready         <= 1'b0;
      o_rdata         <= 32'd0;
      o_overrun       <= 1'b0;
      o_framing_error <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr    <= rptr + 1'b1;
        o_rdata <= {24'd0, mem[rptr[AW-1:0]]};
        o_ready <= 1'b1;
      end else if (!i_request) begin
        o_ready <= 1'b0;
      end
      // A fresh error outranks a coincident clear.
      o_overrun       <= ovr_set |
                         (o_overrun & ~i_clear_errors);
      o_framing_error <= fe_set |
                         (o_framing_error & ~i_clear_errors);
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the peripheral bus, the counterpart of the UART transmitter: it samples the `UART_RX` pin at 8× the bit rate and decodes 8N1 frames. Accepted bytes are pushed into a 64-entry RX FIFO, and the CPU side pops them through the same request/ready handshake the transmitter uses. Line-level errors are reported as sticky status bits.

## Interface
- `PRESCALE`, default `50000000 / (9600 * 8)`: clock cycles per sample tick; 8 sample ticks make one bit period.
- `DEPTH`, default 64: RX FIFO depth in bytes, a power of two.
- `i_clock`  in  1  single clock; all logic is on its rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_request`  in  1  read request from the bus; held high until `o_ready` is seen.
- `o_rdata`  out  32  `{24'd0, byte}`, valid while `o_ready` = 1.
- `o_ready`  out  1  read-data-valid acknowledge.
- `o_empty`  out  1  RX FIFO is empty.
- `o_overrun`  out  1  sticky: a received byte was dropped because the FIFO was full.
- `o_framing_error`  out  1  sticky: a stop bit was sampled as 0.
- `i_clear_errors`  in  1  single-cycle pulse that clears both sticky flags.
- `UART_RX`  in  1  serial line; idles high.

## Operation
- Input synchronizer:
  - `UART_RX` passes through a 2-flop synchronizer, reset to 1.
  - All decoding uses the synchronized value `rx_s`.
- Sample-tick counter:
  - Counts `PRESCALE-1` down to 0, producing a 1-cycle `tick` at 0.
  - It is reloaded when IDLE detects a start edge, so sampling is phase-aligned to that edge.
- FSM states:
  - IDLE: on a 1→0 transition of `rx_s`, reload the tick counter, set `scount`=0, go to START.
  - START: on the 4th tick (mid-bit), if `rx_s`=0 go to DATA with `bidx`=0. If `rx_s`=1 it was a false start; return to IDLE with nothing pushed.
  - DATA: every 8th tick, shift `rx_s` into `shreg[7]`, shifting right (LSB is received first). After the 8th bit, go to STOP.
  - STOP: sample on the 8th tick.
    - If `rx_s`=1 and the FIFO is not full: push `shreg`.
    - If `rx_s`=1 and the FIFO is full: set `o_overrun` and discard the byte.
    - If `rx_s`=0: set `o_framing_error`, discard the byte, go to BREAK.
    - Otherwise go to IDLE.
  - BREAK: wait for `rx_s`=1, then go to IDLE. A new frame cannot start until the line returns high.
- RX FIFO:
  - Binary read and write pointers, each with one extra wrap bit.
  - Full when the indices are equal and the wrap bits differ; empty when the pointers are equal.
  - Pointers wrap modulo 2·DEPTH.
- Read handshake:
  - An edge with `i_request`=1, `o_ready`=0 and FIFO non-empty loads `o_rdata` from the FIFO head, sets `o_ready`=1 and pops one entry, all on that edge.
  - `o_ready` stays 1 while `i_request` stays high. No further pops occur.
  - The first edge with `i_request`=0 clears `o_ready`.
  - A request on an empty FIFO stalls, with `o_ready`=0, until a byte arrives.
- Simultaneous push and pop in the same cycle: both take effect, and the occupancy is unchanged.
- Sticky flags:
  - When `i_clear_errors` and a new error coincide, the error wins and the flag stays 1.

## Timing
- Reset values (`i_reset`=0, asynchronous):
  - `o_ready`=0, `o_rdata`=0, `o_empty`=1, `o_overrun`=0, `o_framing_error`=0.
  - FSM in IDLE, FIFO pointers at 0, synchronizer flops at 1.
- Reset asserted mid-frame aborts the frame immediately; no partial byte is pushed.
- Pin-to-FSM latency: 2 cycles (synchronizer).
- Start edge to mid-start-bit sample: 4·PRESCALE cycles. Data bit n is sampled (4+8·(n+1))·PRESCALE cycles after the edge.
- The stop-bit sample falls at 76·PRESCALE cycles after the edge. The push happens on that same edge, and `o_empty` falls on the following cycle.
- Read latency: `o_ready` rises 1 cycle after `i_request` when data is present.
- Back-to-back frames are supported: IDLE is re-entered at mid-stop, half a bit before the next start edge.

## Test plan
- Single byte, no wait: PRESCALE=2, drive 0xA5 as 8N1 at 16 clocks/bit.
  - `o_empty` falls.
  - A read returns `o_rdata`=0x000000A5 with `o_ready` one cycle after `i_request`.
  - `o_empty` returns to 1.
- Back-to-back stream: drive 0x00, 0xFF, 0x55 with no idle gap.
  - Three reads return them in that order.
  - No flags set.
- Glitch and framing:
  - Drive line low for 4 clocks, then high: false start; nothing is pushed, FSM back in IDLE.
  - Drive a frame with stop bit 0: `o_framing_error`=1, nothing is pushed, no new frame starts until the line is high.
  - Pulse `i_clear_errors`: the flag clears.
- Overrun: receive 65 bytes with no reads.
  - `o_overrun`=1.
  - 64 reads return the first 64 bytes; the 65th was dropped.
- Blocking read and simultaneous push/pop:
  - Request on an empty FIFO: `o_ready` stays 0 until a frame completes, then asserts with that byte.
  - Complete a frame in the same cycle as a pop: occupancy is unchanged.
- Async reset: assert `i_reset`=0 mid-data-bit.
  - All outputs go to their reset values without waiting for a clock edge.
  - After release, a clean 0x3C frame is received correctly.
